// File: rtl/alink_tx_ctrl.sv
// alink_tx_ctrl
// Drains the ALINK TX FIFO one frame at a time. Each frame is a header word
// (channel in [CH_W-1:0], payload length N in [8+LEN_W-1:8]) followed by N
// payload words. The header is consumed locally. A frame is started only once
// all of its words are in the FIFO. Frames on masked channels and frames with
// N=0 are discarded and counted in drop_cnt. All other frames are streamed to
// the PHY through a single registered valid/ready slot.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   txfifo_dout/txempty/txcnt show-ahead FIFO head word, empty flag, occupancy
//   txfifo_pop                combinational pop of the head word
//   reg_flush                 abort pulse; overrides everything in its cycle
//   reg_mask, busy            per-channel drop mask and hold-off bits
//   tx_valid/tx_ready/tx_word output stream handshake and data
//   tx_ch, tx_sof, tx_eof     frame channel and first/last word markers
//   frame_cnt, drop_cnt       wrapping sent / dropped frame counters
module alink_tx_ctrl #(
  parameter int CH_W  = 5,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      txfifo_dout,
  input  logic             txempty,
  input  logic [10:0]      txcnt,
  output logic             txfifo_pop,
  input  logic             reg_flush,
  input  logic [31:0]      reg_mask,
  input  logic [31:0]      busy,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [31:0]      tx_word,
  output logic [CH_W-1:0]  tx_ch,
  output logic             tx_sof,
  output logic             tx_eof,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_SEND,
    S_DROP
  } state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  rem;
  logic [CH_W-1:0]   ch_q;
  logic              first;

  logic [LEN_W-1:0]  hdr_n;
  logic [CH_W-1:0]   hdr_ch;
  logic [10:0]       need;
  logic              slot_free;
  logic              last_word;

  logic              hdr_take;
  logic              load;
  logic              drop_pop;
  logic              sent_inc;
  logic              drop_inc;

  assign hdr_n     = txfifo_dout[8+LEN_W-1:8];
  assign hdr_ch    = txfifo_dout[CH_W-1:0];
  assign need      = 11'(hdr_n) + 11'd1;
  assign slot_free = !tx_valid || tx_ready;
  assign last_word = (rem == LEN_W'(1));

  always_comb begin
    state_nxt  = state;
    txfifo_pop = 1'b0;
    hdr_take   = 1'b0;
    load       = 1'b0;
    drop_pop   = 1'b0;
    sent_inc   = 1'b0;
    drop_inc   = 1'b0;
    if (!reg_flush) begin
      case (state)
        S_IDLE: begin
          if (!txempty) begin
            if (hdr_n == '0) begin
              txfifo_pop = 1'b1;
              drop_inc   = 1'b1;
            end else if (txcnt >= need) begin
              txfifo_pop = 1'b1;
              hdr_take   = 1'b1;
              state_nxt  = reg_mask[hdr_ch] ? S_DROP : S_WAIT_BUSY;
            end
          end
        end
        S_WAIT_BUSY: begin
          if (!busy[ch_q]) state_nxt = S_SEND;
        end
        S_SEND: begin
          if (rem != '0 && slot_free && !txempty) begin
            load       = 1'b1;
            txfifo_pop = 1'b1;
            if (last_word) begin
              sent_inc  = 1'b1;
              state_nxt = S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (rem != '0 && !txempty) begin
            drop_pop   = 1'b1;
            txfifo_pop = 1'b1;
            if (last_word) begin
              drop_inc  = 1'b1;
              state_nxt = S_IDLE;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rem       <= '0;
      ch_q      <= '0;
      first     <= 1'b0;
      tx_valid  <= 1'b0;
      tx_word   <= '0;
      tx_ch     <= '0;
      tx_sof    <= 1'b0;
      tx_eof    <= 1'b0;
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else if (reg_flush) begin
      state    <= S_IDLE;
      rem      <= '0;
      first    <= 1'b0;
      tx_valid <= 1'b0;
      tx_sof   <= 1'b0;
      tx_eof   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hdr_take) begin
        rem   <= hdr_n;
        ch_q  <= hdr_ch;
        first <= 1'b1;
        // The next header can arrive while the previous last word is still
        // stalled in the slot; tx_ch must not change under a held word, so the
        // channel is also carried in ch_q and re-applied on every load.
        if (slot_free) tx_ch <= hdr_ch;
      end
      if (load) begin
        tx_word  <= txfifo_dout;
        tx_valid <= 1'b1;
        tx_sof   <= first;
        tx_eof   <= last_word;
        tx_ch    <= ch_q;
        first    <= 1'b0;
        rem      <= rem - LEN_W'(1);
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
      if (drop_pop) rem <= rem - LEN_W'(1);
      if (sent_inc) frame_cnt <= frame_cnt + 16'd1;
      if (drop_inc) drop_cnt  <= drop_cnt + 16'd1;
    end
  end

endmodule
